// File: rtl/cpa_pkg.sv
// Shared definitions for the sequential carry-propagate adder/subtractor.
//   state_e : controller states
//   nslice  : number of SLICE-bit chunks (cycles) per operation
//   cfg_ok  : legal WIDTH/SLICE combination, checked at elaboration by the top
package cpa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cycles per operation.
  function automatic int unsigned nslice(input int unsigned width,
                                         input int unsigned slice);
    return width / slice;
  endfunction

  // WIDTH must be >= 2, SLICE in [1, WIDTH], and WIDTH an integer multiple of SLICE.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned slice);
    return (width >= 2) && (slice >= 1) && (slice <= width) &&
           ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/cpa_seq_addsub_if.sv
// Operand/result handshake bundle for cpa_seq_addsub.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub[, acc])
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   slave modport  : the adder
//   master modport : the operand source / result consumer
// Optional macro CPA_SEQ_ACCUM_EN adds the acc request bit.
interface cpa_seq_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
`ifdef CPA_SEQ_ACCUM_EN
  logic             acc;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CPA_SEQ_ACCUM_EN
  modport slave (
    input  in_valid, a, b, cin, sub, acc, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, acc, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
`else
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/cpa_slice.sv
// Combinational SLICE-bit ripple adder built from full-adder cells.
//   x_i, y_i   : slice operands
//   ci_i       : carry into bit 0
//   s_c_o      : slice sum
//   co_c_o     : carry out of the slice MSB
//   c_msb_c_o  : carry into the slice MSB (for overflow detection)
module cpa_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] x_i,
  input  logic [SLICE-1:0] y_i,
  input  logic             ci_i,
  output logic [SLICE-1:0] s_c_o,
  output logic             co_c_o,
  output logic             c_msb_c_o
);

  logic [SLICE:0] carry_c;

  assign carry_c[0] = ci_i;

  // Ripple chain of full-adder cells.
  for (genvar i = 0; i < int'(SLICE); i++) begin : g_fa
    assign s_c_o[i]     = x_i[i] ^ y_i[i] ^ carry_c[i];
    assign carry_c[i+1] = (x_i[i] & y_i[i]) | (carry_c[i] & (x_i[i] ^ y_i[i]));
  end

  assign co_c_o    = carry_c[SLICE];
  assign c_msb_c_o = carry_c[SLICE-1];

endmodule

// File: rtl/cpa_seq_addsub.sv
// Multi-cycle carry-propagate adder/subtractor: one SLICE-bit chunk per clock,
// LSB first, with a registered carry between chunks. A single cpa_slice is
// shared across all chunks.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cpa_seq_addsub_if.slave (operand and result handshakes)
// sub=0 computes a+b+cin; sub=1 computes a-b (cin ignored, cout=1 means no borrow).
// Optional macro CPA_SEQ_ACCUM_EN: acc=1 at accept takes operand A from the
// current sum register, giving a running accumulator.
module cpa_seq_addsub
  import cpa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cpa_seq_addsub_if.slave      bus
);

  localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned IDX_W  = $clog2(WIDTH);

  // Reject illegal WIDTH/SLICE at elaboration.
  if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
    $error("cpa_seq_addsub: WIDTH must be >= 2 and a multiple of SLICE");
  end

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [IDX_W-1:0] lo_c;
  logic [SLICE-1:0] slice_s_c;
  logic             slice_co_c;
  logic             slice_cmsb_c;

  // Bit offset of the chunk being processed; SLICE may truncate when
  // SLICE==WIDTH, but then the counter is always zero.
  assign lo_c = IDX_W'(cnt_q) * IDX_W'(SLICE);

  // Shared slice adder.
  cpa_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .x_i       (a_q[lo_c +: SLICE]),
    .y_i       (b_q[lo_c +: SLICE]),
    .ci_i      (carry_q),
    .s_c_o     (slice_s_c),
    .co_c_o    (slice_co_c),
    .c_msb_c_o (slice_cmsb_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
`ifdef CPA_SEQ_ACCUM_EN
          a_d = bus.acc ? sum_q : bus.a;
`else
          a_d = bus.a;
`endif
          // Subtraction as a + ~b + 1.
          b_d        = bus.sub ? ~bus.b : bus.b;
          carry_d    = bus.sub ? 1'b1 : bus.cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        sum_d[lo_c +: SLICE] = slice_s_c;
        carry_d              = slice_co_c;
        cnt_d                = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          cout_d      = slice_co_c;
          ovf_d       = slice_cmsb_c ^ slice_co_c;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Result is released here; new operands wait for IDLE.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cpa_seq_addsub.sv
// Self-checking bench for cpa_seq_addsub (WIDTH=16, SLICE=4): directed cases
// followed by random operations, compared against an arithmetic reference.
// Define CPA_SEQ_ACCUM_EN to also exercise the accumulator mode.
module tb_cpa_seq_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 4;
  localparam int unsigned NS = W / S;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cpa_seq_addsub_if #(.WIDTH(W)) bus ();

  cpa_seq_addsub #(
    .WIDTH (W),
    .SLICE (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference copy of the last completed result (the accumulator source).
  logic [W-1:0] last_sum = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      r    = full[W-1:0];
      c    = (a >= b);                       // no borrow
      v    = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      r    = full[W-1:0];
      c    = full[W];
      v    = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, c, r};
  endfunction

  // One full transaction: accept, latency, result, optional stall, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic acc, input int hold, input string tag);
    logic [W-1:0] aa;
    logic [W+1:0] e;
    int           k;
    aa = acc ? last_sum : a;
    e  = model(aa, b, cin, sub);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
`ifdef CPA_SEQ_ACCUM_EN
    bus.acc      = acc;
`endif
    bus.in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'(NS));
    chk({tag, ".sum"},  32'(bus.sum),  32'(e[W-1:0]));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(e[W]));
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(e[W+1]));
    chk({tag, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    // Stall the consumer while the source pokes in_valid with new operands.
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk({tag, ".hold_sum"},       32'(bus.sum),       32'(e[W-1:0]));
      chk({tag, ".hold_flags"},     32'({bus.ovf, bus.cout}), 32'(e[W+1:W]));
      chk({tag, ".hold_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_in_ready"},  32'(bus.in_ready),  32'd0);
    end
    // Release; in_valid stays high through this edge and must not be taken.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, ".rel_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".rel_in_ready"},  32'(bus.in_ready),  32'd1);
    last_sum = e[W-1:0];
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
`ifdef CPA_SEQ_ACCUM_EN
    bus.acc       = 1'b0;
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.sum",       32'(bus.sum),       32'd0);
    chk("rst.cout",      32'(bus.cout),      32'd0);
    chk("rst.ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;

    // out_ready while idle has no effect.
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("idle_ordy.out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_ordy.in_ready",  32'(bus.in_ready),  32'd1);

    // Directed cases.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, "wrap");
    chk("wrap.const_sum", 32'(last_sum), 32'h0000);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, "ovf_pos");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 3, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 0, "ovf_sub");
    run_op(16'h1000, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1, "cin");

    // Reset mid-BUSY (counter at 2) discards the partial result.
    @(negedge clk);
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.sub      = 1'b0;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.sum",       32'(bus.sum),       32'd0);
    chk("abort.in_ready",  32'(bus.in_ready),  32'd1);
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 0, "post_rst");

`ifdef CPA_SEQ_ACCUM_EN
    // Accumulator: A comes from the previous result, port a is ignored.
    run_op(16'h0010, 16'h0005, 1'b0, 1'b0, 1'b0, 0, "acc_seed");
    run_op(16'hBEEF, 16'h0003, 1'b0, 1'b1, 1'b1, 0, "acc_sub");
    run_op(16'hCAFE, 16'h0100, 1'b1, 1'b0, 1'b1, 1, "acc_add");
`endif

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      logic acc_r;
`ifdef CPA_SEQ_ACCUM_EN
      acc_r = 1'($urandom);
`else
      acc_r = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc_r,
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
